// File: rtl/axi_mem_responder_if.sv
// AXI4 bus between a cache back-end (master) and the memory responder (slave).
// Groups the five AXI channels; clock and reset stay as plain module ports.
//   AW: awid, awaddr, awlen, awsize, awburst, awvalid / awready
//   W : wdata, wstrb, wlast, wvalid / wready
//   B : bid, bresp, bvalid / bready
//   AR: arid, araddr, arlen, arsize, arburst, arvalid / arready
//   R : rid, rdata, rresp, rlast, rvalid / rready
interface axi_mem_responder_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1
);
  logic [AXI_ID_W-1:0]     awid;
  logic [AXI_ADDR_W-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;
  logic [AXI_DATA_W-1:0]   wdata;
  logic [AXI_DATA_W/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [AXI_ID_W-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [AXI_ID_W-1:0]     arid;
  logic [AXI_ADDR_W-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;
  logic [AXI_ID_W-1:0]     rid;
  logic [AXI_DATA_W-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory model backing a cache's m_axi port. Accepts single-beat
// or burst writes with byte strobes and serves read bursts from an internal
// word array. Read and write sides run independent FSMs, one outstanding
// transaction each.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   s_axi - AXI4 slave modport (AW/W/B/AR/R channels)
module axi_mem_responder #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int AXI_ID_W   = 1,
  parameter int MEM_ADDR_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  axi_mem_responder_if.slave s_axi
);
  localparam int BYTE_W = $clog2(AXI_DATA_W/8);
  localparam int STRB_W = AXI_DATA_W/8;
  localparam int DEPTH  = 1 << MEM_ADDR_W;
  localparam logic [2:0] SIZE_FULL = 3'(BYTE_W);
  localparam logic [MEM_ADDR_W-1:0] IDX_ONE = {{(MEM_ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  // WRAP, reserved burst types and narrow sizes run as INCR but report SLVERR.
  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || (size != SIZE_FULL);
  endfunction

  function automatic logic [MEM_ADDR_W-1:0] next_idx(input logic [MEM_ADDR_W-1:0] idx,
                                                     input logic fixed);
    return fixed ? idx : idx + IDX_ONE;
  endfunction

  logic [AXI_DATA_W-1:0] mem [DEPTH];

  w_state_e              w_state_q, w_state_d;
  logic                  awready_q, awready_d;
  logic [AXI_ID_W-1:0]   w_id_q, w_id_d;
  logic                  w_err_q, w_err_d;
  logic [MEM_ADDR_W-1:0] w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [7:0]            w_cnt_q, w_cnt_d;
  logic                  w_fixed_q, w_fixed_d;
  logic                  w_beat;
  logic                  w_cnt_end;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d;
  logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
  logic                  r_err_q, r_err_d;
  logic [MEM_ADDR_W-1:0] r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic                  r_fixed_q, r_fixed_d;
  logic                  r_last;
  logic [AXI_DATA_W-1:0] rdata_q;

  // Address bits above the word index are ignored, so the memory aliases.
  logic unused_addr;
  assign unused_addr = ^{s_axi.awaddr, s_axi.araddr};

  assign w_beat    = (w_state_q == W_DATA) && s_axi.wvalid;
  assign w_cnt_end = (w_cnt_q == w_len_q);

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_err_d   = w_err_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_fixed_d = w_fixed_q;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid && awready_q) begin
          w_id_d    = s_axi.awid;
          w_idx_d   = s_axi.awaddr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
          w_len_d   = s_axi.awlen;
          w_fixed_d = (s_axi.awburst == 2'b00);
          w_err_d   = burst_err(s_axi.awburst, s_axi.awsize);
          w_cnt_d   = 8'd0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid) begin
          w_idx_d = next_idx(w_idx_q, w_fixed_q);
          w_cnt_d = w_cnt_q + 8'd1;
          // Whichever of wlast / beat count comes first ends the burst;
          // disagreement between them is a protocol error.
          if (s_axi.wlast || w_cnt_end) begin
            w_state_d = W_RESP;
            if (s_axi.wlast != w_cnt_end) w_err_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    // Registered ready: rises on the edge that returns the FSM to idle.
    awready_d = (w_state_d == W_IDLE);
  end

  assign r_last = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_err_d   = r_err_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_fixed_d = r_fixed_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid && arready_q) begin
          r_id_d    = s_axi.arid;
          r_idx_d   = s_axi.araddr[MEM_ADDR_W+BYTE_W-1:BYTE_W];
          r_len_d   = s_axi.arlen;
          r_fixed_d = (s_axi.arburst == 2'b00);
          r_err_d   = burst_err(s_axi.arburst, s_axi.arsize);
          r_cnt_d   = 8'd0;
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: begin
        if (s_axi.rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d   = next_idx(r_idx_q, r_fixed_q);
            r_cnt_d   = r_cnt_q + 8'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // Control state: asynchronously reset so a burst aborts immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      w_id_q    <= '0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      r_id_q    <= '0;
      r_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      w_id_q    <= w_id_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      r_id_q    <= r_id_d;
      r_err_q   <= r_err_d;
    end
  end

  // Burst bookkeeping: only meaningful once a transaction is latched.
  always_ff @(posedge clk) begin
    w_idx_q   <= w_idx_d;
    w_len_q   <= w_len_d;
    w_cnt_q   <= w_cnt_d;
    w_fixed_q <= w_fixed_d;
    r_idx_q   <= r_idx_d;
    r_len_q   <= r_len_d;
    r_cnt_q   <= r_cnt_d;
    r_fixed_q <= r_fixed_d;
  end

  // Array: byte-lane writes; the fetch read samples pre-write data, so a
  // same-cycle write and read of one word returns the old value.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx_q][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
    if (r_state_q == R_FETCH) rdata_q <= mem[r_idx_q];
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = (w_state_q == W_DATA);
  assign s_axi.bvalid  = (w_state_q == W_RESP);
  assign s_axi.bid     = w_id_q;
  assign s_axi.bresp   = {w_err_q, 1'b0};
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = (r_state_q == R_DATA);
  assign s_axi.rlast   = r_last;
  assign s_axi.rid     = r_id_q;
  assign s_axi.rresp   = {r_err_q, 1'b0};
  assign s_axi.rdata   = rdata_q;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder (32-bit data, 16-word array so that
// address aliasing and index wrap-around are reachable).
module tb_axi_mem_responder;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 1;
  localparam int MW = 4;
  localparam logic [1:0] FIXED = 2'b00;
  localparam logic [1:0] INCR  = 2'b01;
  localparam logic [1:0] WRAP  = 2'b10;
  localparam logic [1:0] RSVD  = 2'b11;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  axi_mem_responder_if #(.AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW)) axi ();

  axi_mem_responder #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .AXI_ID_W(IW), .MEM_ADDR_W(MW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s_axi(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  burst;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        id;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic id);
    int t;
    t = 0;
    axi.awaddr = addr; axi.awlen = len; axi.awburst = burst; axi.awsize = size; axi.awid = id;
    axi.awvalid = 1'b1;
    while (axi.awready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("awready_wait", 32'(t < 50), 32'd1);
    @(negedge clk);
    axi.awvalid = 1'b0;
    check("wready_after_aw", 32'(axi.wready), 32'd1);
    check("awready_low_in_burst", 32'(axi.awready), 32'd0);
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int t;
    t = 0;
    axi.wdata = data; axi.wstrb = strb; axi.wlast = last; axi.wvalid = 1'b1;
    while (axi.wready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("wready_wait", 32'(t < 50), 32'd1);
    @(negedge clk);
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
  endtask

  task automatic b_recv(output logic [1:0] resp, output logic id);
    int t;
    t = 0;
    while (axi.bvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("bvalid_wait", 32'(t < 50), 32'd1);
    resp = axi.bresp; id = axi.bid;
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    check("awready_after_b", 32'(axi.awready), 32'd1);
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                         input logic [2:0] size, input logic id);
    int t;
    t = 0;
    axi.araddr = addr; axi.arlen = len; axi.arburst = burst; axi.arsize = size; axi.arid = id;
    axi.arvalid = 1'b1;
    while (axi.arready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("arready_wait", 32'(t < 50), 32'd1);
    @(negedge clk);
    axi.arvalid = 1'b0;
    // One cycle after the AR edge: still fetching.
    check("rvalid_at_k1", 32'(axi.rvalid), 32'd0);
    check("arready_low_in_read", 32'(axi.arready), 32'd0);
  endtask

  task automatic r_recv(input int stall, output logic [31:0] data, output logic [1:0] resp,
                        output logic last, output logic id);
    int t;
    logic [31:0] held;
    t = 0;
    while (axi.rvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    check("rvalid_wait", 32'(t < 50), 32'd1);
    for (int s = 0; s < stall; s++) begin
      held = axi.rdata;
      @(negedge clk);
      check("r_stall_valid", 32'(axi.rvalid), 32'd1);
      check("r_stall_hold", axi.rdata, held);
    end
    data = axi.rdata; resp = axi.rresp; last = axi.rlast; id = axi.rid;
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    if (last) check("arready_after_rlast", 32'(axi.arready), 32'd1);
    else      check("rvalid_gap", 32'(axi.rvalid), 32'd0);
  endtask

  task automatic write1(input logic [31:0] addr, input logic [1:0] burst, input logic [2:0] size,
                        input logic [31:0] data, input logic [3:0] strb, input logic id,
                        output logic [1:0] resp, output logic bid);
    aw_send(addr, 8'd0, burst, size, id);
    w_send(data, strb, 1'b1);
    check("bvalid_after_last_w", 32'(axi.bvalid), 32'd1);
    b_recv(resp, bid);
  endtask

  task automatic read1(input logic [31:0] addr, input logic [1:0] burst, input logic [2:0] size,
                       input logic id, output logic [31:0] data, output logic [1:0] resp,
                       output logic last, output logic rid);
    ar_send(addr, 8'd0, burst, size, id);
    @(negedge clk);
    check("rvalid_at_k2", 32'(axi.rvalid), 32'd1);
    r_recv(0, data, resp, last, rid);
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  resp;
    logic        last;
    logic        id;

    n_total = 0; n_pass = 0;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
    axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = '0;
    axi.arburst = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    //            wr    addr    burst size data          strb  id    resp   exp_data
    vecs[0]  = '{1'b1, 32'h40, INCR, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h40, INCR, 3'd2, 32'h0,        4'h0, 1'b1, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 32'h00, INCR, 3'd2, 32'h0,        4'h0, 1'b0, 2'b00, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 32'h08, INCR, 3'd2, 32'h11223344, 4'hF, 1'b1, 2'b00, 32'h0};
    vecs[4]  = '{1'b1, 32'h08, INCR, 3'd2, 32'hAABBCCDD, 4'h5, 1'b0, 2'b00, 32'h0};
    vecs[5]  = '{1'b0, 32'h08, INCR, 3'd2, 32'h0,        4'h0, 1'b1, 2'b00, 32'h11BB33DD};
    vecs[6]  = '{1'b1, 32'h0C, INCR, 3'd2, 32'h01234567, 4'hF, 1'b0, 2'b00, 32'h0};
    vecs[7]  = '{1'b1, 32'h0C, INCR, 3'd2, 32'hFFFFFFFF, 4'h0, 1'b1, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 32'h0C, INCR, 3'd2, 32'h0,        4'h0, 1'b0, 2'b00, 32'h01234567};
    vecs[9]  = '{1'b1, 32'h14, INCR, 3'd2, 32'h00000000, 4'hF, 1'b0, 2'b00, 32'h0};
    vecs[10] = '{1'b1, 32'h14, INCR, 3'd2, 32'hFFFFFFFF, 4'hA, 1'b1, 2'b00, 32'h0};
    vecs[11] = '{1'b0, 32'h14, INCR, 3'd2, 32'h0,        4'h0, 1'b1, 2'b00, 32'hFF00FF00};
    vecs[12] = '{1'b1, 32'h10, INCR, 3'd1, 32'h55AA55AA, 4'hF, 1'b0, 2'b10, 32'h0};
    vecs[13] = '{1'b0, 32'h10, INCR, 3'd2, 32'h0,        4'h0, 1'b0, 2'b00, 32'h55AA55AA};
    vecs[14] = '{1'b0, 32'h10, RSVD, 3'd2, 32'h0,        4'h0, 1'b1, 2'b10, 32'h55AA55AA};
    vecs[15] = '{1'b1, 32'h18, FIXED,3'd2, 32'h0F0F0F0F, 4'hF, 1'b1, 2'b00, 32'h0};
    vecs[16] = '{1'b0, 32'h18, FIXED,3'd2, 32'h0,        4'h0, 1'b0, 2'b00, 32'h0F0F0F0F};

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_awready", 32'(axi.awready), 32'd0);
    check("rst_arready", 32'(axi.arready), 32'd0);
    check("rst_wready",  32'(axi.wready),  32'd0);
    check("rst_bvalid",  32'(axi.bvalid),  32'd0);
    check("rst_rvalid",  32'(axi.rvalid),  32'd0);
    check("rst_rlast",   32'(axi.rlast),   32'd0);
    check("rst_bresp",   32'(axi.bresp),   32'd0);
    check("rst_rresp",   32'(axi.rresp),   32'd0);
    check("rst_bid",     32'(axi.bid),     32'd0);
    check("rst_rid",     32'(axi.rid),     32'd0);
    @(negedge clk); @(negedge clk);
    check("rst_awready_held", 32'(axi.awready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("awready_before_edge", 32'(axi.awready), 32'd0);
    @(negedge clk);
    check("awready_first_edge", 32'(axi.awready), 32'd1);
    check("arready_first_edge", 32'(axi.arready), 32'd1);

    // Single-beat vector table
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].wr) begin
        write1(vecs[i].addr, vecs[i].burst, vecs[i].size, vecs[i].data, vecs[i].strb,
               vecs[i].id, resp, id);
        check($sformatf("v%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_bid", i), 32'(id), 32'(vecs[i].id));
      end else begin
        read1(vecs[i].addr, vecs[i].burst, vecs[i].size, vecs[i].id, d, resp, last, id);
        check($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
        check($sformatf("v%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
        check($sformatf("v%0d_rlast", i), 32'(last), 32'd1);
        check($sformatf("v%0d_rid", i), 32'(id), 32'(vecs[i].id));
      end
    end

    // Line refill: 8-beat write at 0x100 (words 0..7), read back with stalls
    aw_send(32'h100, 8'd7, INCR, 3'd2, 1'b1);
    for (int i = 0; i < 8; i++) w_send(32'(i), 4'hF, 1'(i == 7));
    check("refill_bvalid", 32'(axi.bvalid), 32'd1);
    b_recv(resp, id);
    check("refill_bresp", 32'(resp), 32'd0);
    check("refill_bid", 32'(id), 32'd1);
    ar_send(32'h100, 8'd7, INCR, 3'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      r_recv(1, d, resp, last, id);
      check($sformatf("refill_rdata%0d", i), d, 32'(i));
      check($sformatf("refill_rlast%0d", i), 32'(last), 32'(i == 7));
      check($sformatf("refill_rresp%0d", i), 32'(resp), 32'd0);
    end

    // Wrap-around: INCR len 3 from word 14 writes words 14, 15, 0, 1
    aw_send(32'h38, 8'd3, INCR, 3'd2, 1'b0);
    for (int i = 0; i < 4; i++) w_send(32'hA0000000 | 32'(i), 4'hF, 1'(i == 3));
    b_recv(resp, id);
    check("wrap_bresp", 32'(resp), 32'd0);
    read1(32'h38, INCR, 3'd2, 1'b0, d, resp, last, id); check("wrap_w14", d, 32'hA0000000);
    read1(32'h3C, INCR, 3'd2, 1'b0, d, resp, last, id); check("wrap_w15", d, 32'hA0000001);
    read1(32'h00, INCR, 3'd2, 1'b0, d, resp, last, id); check("wrap_w0",  d, 32'hA0000002);
    read1(32'h04, INCR, 3'd2, 1'b0, d, resp, last, id); check("wrap_w1",  d, 32'hA0000003);
    ar_send(32'h38, 8'd3, INCR, 3'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      r_recv(0, d, resp, last, id);
      check($sformatf("wrap_burst%0d", i), d, 32'hA0000000 | 32'(i));
    end

    // WRAP burst type: executes as INCR, SLVERR response
    aw_send(32'h20, 8'd1, WRAP, 3'd2, 1'b1);
    w_send(32'hB0, 4'hF, 1'b0);
    w_send(32'hB1, 4'hF, 1'b1);
    b_recv(resp, id);
    check("wrapburst_bresp", 32'(resp), 32'd2);
    check("wrapburst_bid", 32'(id), 32'd1);
    ar_send(32'h20, 8'd1, INCR, 3'd2, 1'b0);
    r_recv(0, d, resp, last, id); check("wrapburst_d0", d, 32'hB0); check("wrapburst_l0", 32'(last), 32'd0);
    r_recv(0, d, resp, last, id); check("wrapburst_d1", d, 32'hB1); check("wrapburst_l1", 32'(last), 32'd1);

    // FIXED burst: all beats land on the same word
    aw_send(32'h24, 8'd2, FIXED, 3'd2, 1'b0);
    for (int i = 0; i < 3; i++) w_send(32'hE0 + 32'(i), 4'hF, 1'(i == 2));
    b_recv(resp, id);
    check("fixed_bresp", 32'(resp), 32'd0);
    read1(32'h24, INCR, 3'd2, 1'b0, d, resp, last, id); check("fixed_word", d, 32'hE2);

    // Early wlast: len 3 but wlast on beat 1 -> two beats, SLVERR, word 12 untouched
    write1(32'h30, INCR, 3'd2, 32'h12121212, 4'hF, 1'b0, resp, id);
    aw_send(32'h28, 8'd3, INCR, 3'd2, 1'b0);
    w_send(32'hC0, 4'hF, 1'b0);
    w_send(32'hC1, 4'hF, 1'b1);
    check("early_bvalid", 32'(axi.bvalid), 32'd1);
    check("early_wready", 32'(axi.wready), 32'd0);
    b_recv(resp, id);
    check("early_bresp", 32'(resp), 32'd2);
    ar_send(32'h28, 8'd2, INCR, 3'd2, 1'b0);
    r_recv(0, d, resp, last, id); check("early_w10", d, 32'hC0);
    r_recv(0, d, resp, last, id); check("early_w11", d, 32'hC1);
    r_recv(0, d, resp, last, id); check("early_w12", d, 32'h12121212);

    // Missing wlast: len 0 without wlast still ends after one beat, SLVERR
    aw_send(32'h34, 8'd0, INCR, 3'd2, 1'b1);
    w_send(32'hD0, 4'hF, 1'b0);
    check("late_bvalid", 32'(axi.bvalid), 32'd1);
    b_recv(resp, id);
    check("late_bresp", 32'(resp), 32'd2);
    read1(32'h34, INCR, 3'd2, 1'b0, d, resp, last, id); check("late_word", d, 32'hD0);

    // Reset during R_DATA aborts the read immediately
    ar_send(32'h00, 8'd3, INCR, 3'd2, 1'b1);
    @(negedge clk);
    check("midrd_rvalid_pre", 32'(axi.rvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrd_rvalid", 32'(axi.rvalid), 32'd0);
    check("midrd_rlast", 32'(axi.rlast), 32'd0);
    check("midrd_arready", 32'(axi.arready), 32'd0);
    check("midrd_rid", 32'(axi.rid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrd_arready_pre_edge", 32'(axi.arready), 32'd0);
    @(negedge clk);
    check("midrd_arready_edge", 32'(axi.arready), 32'd1);
    check("midrd_rvalid_after", 32'(axi.rvalid), 32'd0);
    read1(32'h38, INCR, 3'd2, 1'b1, d, resp, last, id);
    check("post_rst_rdata", d, 32'hA0000000);
    check("post_rst_rlast", 32'(last), 32'd1);
    check("post_rst_rid", 32'(id), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
